// File: rtl/i2c_tmp_slave_if.sv
// Board I2C pins as seen by the TMP-style target.
// The target drives SDA only as an open-drain pull-down enable.
interface i2c_tmp_slave_if;
    logic scl_in;
    logic sda_in;
    logic sda_drive_low;

    modport slave  (input scl_in, input sda_in, output sda_drive_low);
    modport master (output scl_in, output sda_in, input sda_drive_low);
endinterface

// File: rtl/i2c_tmp_slave.sv
// I2C target emulating a TMP-style temperature sensor: pointer register,
// read-only temperature word and three writable 16-bit registers.
module i2c_tmp_slave #(
    parameter logic [6:0]  DEV_ADDR    = 7'h48,
    parameter logic [15:0] CFG_RESET   = 16'h60A0,
    parameter logic [15:0] TLOW_RESET  = 16'h4B00,
    parameter logic [15:0] THIGH_RESET = 16'h5000
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    i2c_tmp_slave_if.slave        bus,
    input  logic [15:0]           temp_value,
    output logic [15:0]           cfg_reg,
    output logic [15:0]           tlow_reg,
    output logic [15:0]           thigh_reg,
    output logic                  wr_strobe,
    output logic [1:0]            wr_ptr,
    output logic                  busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_MSB, WR_MSB_ACK,
        WR_LSB, WR_LSB_ACK, RD_MSB, RD_MACK1, RD_LSB, RD_MACK2, WAIT_STOP
    } state_t;

    state_t      state_r, state_nxt_s;
    logic        scl_meta_r, scl_sync_r, scl_prev_r;
    logic        sda_meta_r, sda_sync_r, sda_prev_r;
    logic        scl_rise_s, scl_fall_s, start_s, stop_s, sda_s;
    logic [2:0]  bit_cnt_r;
    logic [6:0]  shift_r;
    logic [7:0]  msb_r;
    logic [15:0] tx_r;
    logic [15:0] snap_s;
    logic [1:0]  ptr_r;
    logic        rw_r;
    logic        sda_drive_low_r;
    logic        wr_strobe_r;
    logic [1:0]  wr_ptr_r;
    logic        busy_r;
    logic [15:0] cfg_r, tlow_r, thigh_r;

    function automatic logic [15:0] reg_sel(input logic [1:0] p, input logic [15:0] t,
                                            input logic [15:0] c, input logic [15:0] l,
                                            input logic [15:0] h);
        logic [15:0] v;
        case (p)
            2'd0:    v = t;
            2'd1:    v = c;
            2'd2:    v = l;
            2'd3:    v = h;
            default: v = t;
        endcase
        return v;
    endfunction

    // Pad synchronizers plus one history stage for edge detection
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_meta_r <= 1'b1; scl_sync_r <= 1'b1; scl_prev_r <= 1'b1;
            sda_meta_r <= 1'b1; sda_sync_r <= 1'b1; sda_prev_r <= 1'b1;
        end else begin
            scl_meta_r <= bus.scl_in; scl_sync_r <= scl_meta_r; scl_prev_r <= scl_sync_r;
            sda_meta_r <= bus.sda_in; sda_sync_r <= sda_meta_r; sda_prev_r <= sda_sync_r;
        end
    end

    assign sda_s      = sda_sync_r;
    assign scl_rise_s = scl_sync_r & ~scl_prev_r;
    assign scl_fall_s = ~scl_sync_r & scl_prev_r;
    assign start_s    = scl_sync_r & scl_prev_r & sda_prev_r & ~sda_sync_r;
    assign stop_s     = scl_sync_r & scl_prev_r & ~sda_prev_r & sda_sync_r;
    assign snap_s     = reg_sel(ptr_r, temp_value, cfg_r, tlow_r, thigh_r);

    // State register
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_nxt_s;
    end

    // Next-state decode; byte states advance on the 8th SCL rise, ACK states
    // leave on the second SCL fall (the one closing the 9th clock)
    always_comb begin
        state_nxt_s = state_r;
        if (start_s) begin
            state_nxt_s = ADDR;
        end else if (stop_s) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                ADDR:       if (scl_rise_s && bit_cnt_r == 3'd7)
                                state_nxt_s = (shift_r == DEV_ADDR) ? ADDR_ACK : WAIT_STOP;
                ADDR_ACK:   if (scl_fall_s && sda_drive_low_r) state_nxt_s = rw_r ? RD_MSB : PTR;
                PTR:        if (scl_rise_s && bit_cnt_r == 3'd7) state_nxt_s = PTR_ACK;
                PTR_ACK:    if (scl_fall_s && sda_drive_low_r) state_nxt_s = WR_MSB;
                WR_MSB:     if (scl_rise_s && bit_cnt_r == 3'd7) state_nxt_s = WR_MSB_ACK;
                WR_MSB_ACK: if (scl_fall_s && sda_drive_low_r) state_nxt_s = WR_LSB;
                WR_LSB:     if (scl_rise_s && bit_cnt_r == 3'd7) state_nxt_s = WR_LSB_ACK;
                WR_LSB_ACK: if (scl_fall_s && sda_drive_low_r) state_nxt_s = WR_MSB;
                RD_MSB:     if (scl_rise_s && bit_cnt_r == 3'd7) state_nxt_s = RD_MACK1;
                RD_MACK1:   if (scl_rise_s) state_nxt_s = sda_s ? WAIT_STOP : RD_LSB;
                RD_LSB:     if (scl_rise_s && bit_cnt_r == 3'd7) state_nxt_s = RD_MACK2;
                RD_MACK2:   if (scl_rise_s) state_nxt_s = sda_s ? WAIT_STOP : RD_MSB;
                default:    state_nxt_s = state_r;
            endcase
        end
    end

    // Datapath: shifting, register commit, SDA drive and busy flag
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_r <= 3'd0; shift_r <= 7'd0; msb_r <= 8'd0; tx_r <= 16'd0;
            ptr_r <= 2'd0; rw_r <= 1'b0; sda_drive_low_r <= 1'b0;
            wr_strobe_r <= 1'b0; wr_ptr_r <= 2'd0; busy_r <= 1'b0;
            cfg_r <= CFG_RESET; tlow_r <= TLOW_RESET; thigh_r <= THIGH_RESET;
        end else begin
            wr_strobe_r <= 1'b0;
            if (start_s || state_nxt_s != state_r) bit_cnt_r <= 3'd0;
            else if (scl_rise_s)                   bit_cnt_r <= bit_cnt_r + 3'd1;

            if (state_nxt_s == IDLE || state_nxt_s == WAIT_STOP) busy_r <= 1'b0;
            else if (state_nxt_s == ADDR_ACK)                     busy_r <= 1'b1;

            if (start_s || stop_s) begin
                sda_drive_low_r <= 1'b0;
            end else begin
                case (state_r)
                    ADDR, PTR, WR_MSB: if (scl_rise_s) begin
                        shift_r <= {shift_r[5:0], sda_s};
                        if (bit_cnt_r == 3'd7) begin
                            if (state_r == ADDR)     rw_r  <= sda_s;
                            else if (state_r == PTR) ptr_r <= {shift_r[0], sda_s};
                            else                     msb_r <= {shift_r, sda_s};
                        end
                    end
                    WR_LSB: if (scl_rise_s) begin
                        shift_r <= {shift_r[5:0], sda_s};
                        // Pointer 0 is the read-only temperature: ACKed, never committed
                        if (bit_cnt_r == 3'd7 && ptr_r != 2'd0) begin
                            wr_strobe_r <= 1'b1;
                            wr_ptr_r    <= ptr_r;
                            case (ptr_r)
                                2'd1:    cfg_r   <= {msb_r, shift_r, sda_s};
                                2'd2:    tlow_r  <= {msb_r, shift_r, sda_s};
                                2'd3:    thigh_r <= {msb_r, shift_r, sda_s};
                                default: cfg_r   <= cfg_r;
                            endcase
                        end
                    end
                    ADDR_ACK: if (scl_fall_s) begin
                        if (!sda_drive_low_r) begin
                            sda_drive_low_r <= 1'b1;
                        end else if (rw_r) begin
                            sda_drive_low_r <= ~snap_s[15];
                            tx_r            <= {snap_s[14:0], 1'b0};
                        end else begin
                            sda_drive_low_r <= 1'b0;
                        end
                    end
                    PTR_ACK, WR_MSB_ACK, WR_LSB_ACK:
                        if (scl_fall_s) sda_drive_low_r <= ~sda_drive_low_r;
                    RD_MSB, RD_LSB: if (scl_fall_s) begin
                        sda_drive_low_r <= ~tx_r[15];
                        tx_r            <= {tx_r[14:0], 1'b0};
                    end
                    RD_MACK1, RD_MACK2: begin
                        if (scl_fall_s)                                sda_drive_low_r <= 1'b0;
                        else if (scl_rise_s && state_nxt_s == RD_MSB) tx_r <= snap_s;
                    end
                    default: sda_drive_low_r <= 1'b0;
                endcase
            end
        end
    end

    assign bus.sda_drive_low = sda_drive_low_r;
    assign cfg_reg   = cfg_r;
    assign tlow_reg  = tlow_r;
    assign thigh_reg = thigh_r;
    assign wr_strobe = wr_strobe_r;
    assign wr_ptr    = wr_ptr_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_i2c_tmp_slave.sv
// Directed bench for i2c_tmp_slave: bit-banged I2C master with open-drain SDA.
module tb_i2c_tmp_slave;
    localparam int H = 10;

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic        scl_m   = 1'b1;
    logic        sda_m   = 1'b1;
    logic [15:0] temp_value = 16'h0000;
    logic [15:0] cfg_reg, tlow_reg, thigh_reg;
    logic        wr_strobe, busy;
    logic [1:0]  wr_ptr;

    int n_tests = 0;
    int n_fail  = 0;
    int strobe_cycles = 0;
    int drv_cycles    = 0;

    i2c_tmp_slave_if bus();
    assign bus.scl_in = scl_m;
    assign bus.sda_in = sda_m & ~bus.sda_drive_low;

    i2c_tmp_slave dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .temp_value (temp_value),
        .cfg_reg    (cfg_reg),
        .tlow_reg   (tlow_reg),
        .thigh_reg  (thigh_reg),
        .wr_strobe  (wr_strobe),
        .wr_ptr     (wr_ptr),
        .busy       (busy)
    );

    always #25 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        if (wr_strobe)         strobe_cycles <= strobe_cycles + 1;
        if (bus.sda_drive_low) drv_cycles    <= drv_cycles + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic bit_out(input logic b);
        sda_m = b; wait_clk(H);
        scl_m = 1'b1; wait_clk(H);
        scl_m = 1'b0; wait_clk(2);
    endtask

    task automatic bit_in(output logic b);
        sda_m = 1'b1; wait_clk(H);
        scl_m = 1'b1; wait_clk(H / 2);
        b = bus.sda_in; wait_clk(H / 2);
        scl_m = 1'b0; wait_clk(2);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; scl_m = 1'b1; wait_clk(H);
        sda_m = 1'b0; wait_clk(H);
        scl_m = 1'b0; wait_clk(2);
    endtask

    task automatic i2c_rstart();
        sda_m = 1'b1; wait_clk(H);
        scl_m = 1'b1; wait_clk(H);
        sda_m = 1'b0; wait_clk(H);
        scl_m = 1'b0; wait_clk(2);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clk(H);
        scl_m = 1'b1; wait_clk(H);
        sda_m = 1'b1; wait_clk(H);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_out(b[i]);
        bit_in(s);
        ack = ~s;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        for (int i = 7; i >= 0; i--) bit_in(d[i]);
        bit_out(~ack);
    endtask

    initial begin
        logic       a;
        logic [7:0] d;
        int         s0, d0;

        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(3);
        check_eq("rst_sda",   {31'd0, bus.sda_drive_low}, 32'd0);
        check_eq("rst_busy",  {31'd0, busy}, 32'd0);
        check_eq("rst_strb",  {31'd0, wr_strobe}, 32'd0);
        check_eq("rst_wrptr", {30'd0, wr_ptr}, 32'd0);
        check_eq("rst_cfg",   {16'd0, cfg_reg}, 32'h60A0);
        check_eq("rst_tlow",  {16'd0, tlow_reg}, 32'h4B00);
        check_eq("rst_thigh", {16'd0, thigh_reg}, 32'h5000);

        // Config write 0x60A0 at pointer 1
        s0 = strobe_cycles;
        i2c_start();
        write_byte(8'h90, a); check_eq("cfg_addr_ack", {31'd0, a}, 32'd1);
        check_eq("cfg_busy", {31'd0, busy}, 32'd1);
        write_byte(8'h01, a); check_eq("cfg_ptr_ack", {31'd0, a}, 32'd1);
        write_byte(8'h60, a); check_eq("cfg_msb_ack", {31'd0, a}, 32'd1);
        write_byte(8'hA0, a); check_eq("cfg_lsb_ack", {31'd0, a}, 32'd1);
        i2c_stop();
        check_eq("cfg_val",    {16'd0, cfg_reg}, 32'h60A0);
        check_eq("cfg_strobe", strobe_cycles - s0, 32'd1);
        check_eq("cfg_wrptr",  {30'd0, wr_ptr}, 32'd1);
        check_eq("cfg_busy_end", {31'd0, busy}, 32'd0);

        // T_LOW write 0x1234 at pointer 2
        s0 = strobe_cycles;
        i2c_start();
        write_byte(8'h90, a); write_byte(8'h02, a);
        write_byte(8'h12, a); write_byte(8'h34, a);
        check_eq("tlow_ack", {31'd0, a}, 32'd1);
        i2c_stop();
        check_eq("tlow_val",    {16'd0, tlow_reg}, 32'h1234);
        check_eq("tlow_strobe", strobe_cycles - s0, 32'd1);
        check_eq("tlow_wrptr",  {30'd0, wr_ptr}, 32'd2);

        // Temperature read with repeated START
        temp_value = 16'h1900;
        i2c_start();
        write_byte(8'h90, a); write_byte(8'h00, a);
        i2c_rstart();
        write_byte(8'h91, a); check_eq("temp_rd_ack", {31'd0, a}, 32'd1);
        read_byte(d, 1'b1); check_eq("temp_msb", {24'd0, d}, 32'h19);
        read_byte(d, 1'b0); check_eq("temp_lsb", {24'd0, d}, 32'h00);
        check_eq("temp_sda_rel", {31'd0, bus.sda_drive_low}, 32'd0);
        i2c_stop();

        // Foreign address 0x92: no ACK, SDA never driven
        d0 = drv_cycles;
        i2c_start();
        write_byte(8'h92, a); check_eq("bad_addr_ack", {31'd0, a}, 32'd0);
        check_eq("bad_addr_busy", {31'd0, busy}, 32'd0);
        write_byte(8'h01, a);
        i2c_stop();
        check_eq("bad_addr_drv", drv_cycles - d0, 32'd0);
        check_eq("bad_addr_cfg", {16'd0, cfg_reg}, 32'h60A0);

        // STOP after MSB only: no commit
        s0 = strobe_cycles;
        i2c_start();
        write_byte(8'h90, a); write_byte(8'h03, a); write_byte(8'h55, a);
        i2c_stop();
        check_eq("part_thigh",  {16'd0, thigh_reg}, 32'h5000);
        check_eq("part_strobe", strobe_cycles - s0, 32'd0);

        // Write to temperature pointer: ACKed, discarded
        s0 = strobe_cycles;
        i2c_start();
        write_byte(8'h90, a); write_byte(8'h00, a);
        write_byte(8'h12, a); write_byte(8'h34, a);
        check_eq("p0_ack", {31'd0, a}, 32'd1);
        i2c_stop();
        check_eq("p0_strobe", strobe_cycles - s0, 32'd0);

        // Read at persisted pointer 0, three bytes to exercise wrap
        temp_value = 16'h0A5C;
        i2c_start();
        write_byte(8'h91, a);
        read_byte(d, 1'b1); check_eq("p0_rd_b0", {24'd0, d}, 32'h0A);
        read_byte(d, 1'b1); check_eq("p0_rd_b1", {24'd0, d}, 32'h5C);
        read_byte(d, 1'b0); check_eq("p0_rd_b2", {24'd0, d}, 32'h0A);
        i2c_stop();

        // T_HIGH read-back through pointer 3
        i2c_start();
        write_byte(8'h90, a); write_byte(8'h03, a);
        i2c_rstart();
        write_byte(8'h91, a);
        read_byte(d, 1'b1); check_eq("thigh_rd_msb", {24'd0, d}, 32'h50);
        read_byte(d, 1'b0); check_eq("thigh_rd_lsb", {24'd0, d}, 32'h00);
        i2c_stop();

        // Reset asserted while the address ACK is being driven
        i2c_start();
        for (int i = 7; i >= 0; i--) bit_out(d[i] & 1'b0 | (8'h90 >> i) & 8'h01);
        sda_m = 1'b1;
        wait_clk(4);
        check_eq("mid_ack_drv",  {31'd0, bus.sda_drive_low}, 32'd1);
        check_eq("mid_ack_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_sda",  {31'd0, bus.sda_drive_low}, 32'd0);
        check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("mid_rst_tlow", {16'd0, tlow_reg}, 32'h4B00);
        check_eq("mid_rst_wptr", {30'd0, wr_ptr}, 32'd0);
        wait_clk(3);
        scl_m = 1'b1; sda_m = 1'b1;
        rst_n = 1'b1;
        wait_clk(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        repeat (60000) @(posedge sys_clk);
        $display("FAIL watchdog: run exceeded 60000 cycles, expected completion earlier");
        $fatal(1);
    end

endmodule
